check_time_and_coin: RTL

CHECK_TIME_AND_COIN -- requirements
Module: check_time_and_coin

---
 rtl/vending_machine_def.sv | 40 ++++
 rtl/change_coin_select.sv | 22 ++
 rtl/check_time_and_coin.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vending_machine_def.sv
// rtl/vending_machine_def.sv - shared vending machine widths, coin/item tables and FSM states
package vending_machine_def;

   localparam int kNumCoins  = 3;
   localparam int kNumItems  = 4;
   localparam int kTotalBits = 31;

   // Index 0 is the smallest coin; the greedy selector relies on ascending order.
   localparam logic [kNumCoins-1:0][31:0] kCoinValue = {32'd1000, 32'd500, 32'd100};
   localparam logic [kNumItems-1:0][31:0] kItemPrice = {32'd2000, 32'd1000, 32'd500, 32'd400};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_RETURN = 2'b10
   } state_e;

   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

   function automatic logic [kTotalBits-1:0] coin_amount(input logic [kNumCoins-1:0] coin);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < kNumCoins; i++) begin
         if (coin[i]) v = v | kCoinValue[i];
      end
      return kTotalBits'(v);
   endfunction

   function automatic logic [kTotalBits-1:0] item_price(input logic [kNumItems-1:0] item);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < kNumItems; i++) begin
         if (item[i]) v = v | kItemPrice[i];
      end
      return kTotalBits'(v);
   endfunction

endpackage

// File: rtl/change_coin_select.sv
// rtl/change_coin_select.sv - greedy pick of the largest coin not exceeding the remaining total
module change_coin_select
   import vending_machine_def::*;
(
   input  logic [kTotalBits-1:0] i_total,
   output logic [kNumCoins-1:0]  o_coin,
   output logic [kTotalBits-1:0] o_value
);

   always_comb begin
      o_coin  = '0;
      o_value = '0;
      // Ascending scan: the last fitting coin wins, which is the largest one.
      for (int i = 0; i < kNumCoins; i++) begin
         if (kCoinValue[i] <= 32'(i_total)) begin
            o_coin  = kNumCoins'(1) << i;
            o_value = kTotalBits'(kCoinValue[i]);
         end
      end
   end

endmodule

// File: rtl/check_time_and_coin.sv
// rtl/check_time_and_coin.sv - credit accumulator with inactivity timeout and greedy change return
module check_time_and_coin
   import vending_machine_def::*;
#(
   parameter int kWaitTime = 10,
   parameter int kMaxTotal = 100000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [kNumCoins-1:0]  i_input_coin,
   input  logic [kNumItems-1:0]  i_output_item,
   input  logic                  i_trigger_return,
   output logic [kTotalBits-1:0] o_input_total,
   output logic [31:0]           o_wait_time,
   output logic [kNumCoins-1:0]  o_return_coin,
   output logic                  o_busy
);

   localparam logic [kTotalBits:0] kMaxTotalW = (kTotalBits+1)'(kMaxTotal);
   localparam logic [31:0]         kWaitTimeW = 32'(kWaitTime);

   state_e                state_q, state_d;
   logic [kTotalBits-1:0] total_q, total_d;
   logic [31:0]           wait_q, wait_d;
   logic [kNumCoins-1:0]  ret_coin_q, ret_coin_d;
   logic [kTotalBits-1:0] ret_amt_q, ret_amt_d;
   logic                  busy_q, busy_d;

   logic                  coin_vld, grant_vld, coin_ok, grant_ok;
   logic [kTotalBits-1:0] coin_amt, price_amt, avail;
   logic [kTotalBits:0]   sum_w;
   logic [kNumCoins-1:0]  sel_coin;
   logic [kTotalBits-1:0] sel_value;

   assign coin_vld  = is_onehot(32'(i_input_coin));
   assign grant_vld = is_onehot(32'(i_output_item));
   assign coin_amt  = coin_amount(i_input_coin);
   assign price_amt = item_price(i_output_item);

   // Coin is applied first so a same-cycle grant may spend the new credit.
   assign sum_w    = {1'b0, total_q} + {1'b0, coin_amt};
   assign coin_ok  = coin_vld && (sum_w <= kMaxTotalW);
   assign avail    = coin_ok ? sum_w[kTotalBits-1:0] : total_q;
   assign grant_ok = grant_vld && (price_amt <= avail);

   always_comb begin
      state_d = state_q;
      total_d = total_q;
      wait_d  = wait_q;
      case (state_q)
         ST_IDLE: begin
            total_d = '0;
            wait_d  = '0;
            if (coin_vld && ({1'b0, coin_amt} <= kMaxTotalW)) begin
               state_d = ST_ACTIVE;
               total_d = coin_amt;
               wait_d  = kWaitTimeW;
            end
         end
         ST_ACTIVE: begin
            if (i_trigger_return || (wait_q == 32'd0)) begin
               wait_d  = '0;
               state_d = (total_q == '0) ? ST_IDLE : ST_RETURN;
            end else if (coin_ok || grant_ok) begin
               total_d = avail - (grant_ok ? price_amt : '0);
               wait_d  = kWaitTimeW;
            end else begin
               wait_d = wait_q - 32'd1;
            end
         end
         ST_RETURN: begin
            wait_d = '0;
            // A remainder no coin can pay out is dropped rather than stalling the FSM.
            if ((ret_amt_q == '0) || (ret_amt_q > total_q)) begin
               state_d = ST_IDLE;
               total_d = '0;
            end else begin
               total_d = total_q - ret_amt_q;
               state_d = (total_q == ret_amt_q) ? ST_IDLE : ST_RETURN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            total_d = '0;
            wait_d  = '0;
         end
      endcase
   end

   change_coin_select u_change_coin_select (
      .i_total (total_d),
      .o_coin  (sel_coin),
      .o_value (sel_value)
   );

   // The coin shown during a RETURN cycle is the one deducted at the end of it.
   assign busy_d     = (state_d == ST_RETURN);
   assign ret_coin_d = busy_d ? sel_coin : '0;
   assign ret_amt_d  = busy_d ? sel_value : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         total_q    <= '0;
         wait_q     <= '0;
         ret_coin_q <= '0;
         ret_amt_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         total_q    <= total_d;
         wait_q     <= wait_d;
         ret_coin_q <= ret_coin_d;
         ret_amt_q  <= ret_amt_d;
         busy_q     <= busy_d;
      end
   end

   assign o_input_total = total_q;
   assign o_wait_time   = wait_q;
   assign o_return_coin = ret_coin_q;
   assign o_busy        = busy_q;

endmodule
